// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registers ALU results and aligns data-bus load returns for writeback.
// Optional ACK_TIMEOUT_EN adds an ack-wait counter that aborts a stuck load with a bus_err pulse.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_wreg,
  input  logic [4:0]  mem_wd,
  input  logic [31:0] mem_wdata,
  input  logic        mem_is_load,
  input  logic [2:0]  mem_load_type,
  input  logic [1:0]  mem_addr_lo,
  input  logic        flush,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic        bus_err
);

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e      state_q, state_d;
  logic        wreg_q, wreg_d;
  logic [4:0]  wd_q, wd_d;
  logic [2:0]  ltype_q, ltype_d;
  logic [1:0]  lo_q, lo_d;
  logic        we_d;
  logic [4:0]  waddr_d;
  logic [31:0] wdata_d;
  logic [31:0] load_data;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef ACK_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout;
  logic            err_d;

  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  // Lane select and extension of the returned word.
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = dbus_rdata[{lo_q, 3'b000} +: 8];
    lane_h = lo_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (ltype_q)
      3'd0:    load_data = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_data = {24'd0, lane_b};
      3'd2:    load_data = {{16{lane_h[15]}}, lane_h};
      3'd3:    load_data = {16'd0, lane_h};
      default: load_data = dbus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wreg_d  = wreg_q;
    wd_d    = wd_q;
    ltype_d = ltype_q;
    lo_d    = lo_q;
    we_d    = 1'b0;
    waddr_d = wb_waddr;
    wdata_d = wb_wdata;
`ifdef ACK_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (mem_valid && !flush) begin
          if (mem_is_load) begin
            wreg_d  = mem_wreg;
            wd_d    = mem_wd;
            ltype_d = mem_load_type;
            lo_d    = mem_addr_lo;
            state_d = StWait;
`ifdef ACK_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            we_d    = mem_wreg && (mem_wd != 5'd0);
            waddr_d = mem_wd;
            wdata_d = mem_wdata;
          end
        end
      end
      StWait: begin
        if (dbus_ack) begin
          state_d = StIdle;
          // A flush arriving with the ack kills the write.
          if (!flush) begin
            we_d    = wreg_q && (wd_q != 5'd0);
            waddr_d = wd_q;
            wdata_d = load_data;
          end
        end else if (flush) begin
          state_d = StDrain;
`ifdef ACK_TIMEOUT_EN
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = StIdle;
          err_d   = 1'b1;
          we_d    = wreg_q && (wd_q != 5'd0);
          waddr_d = wd_q;
          wdata_d = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      StDrain: begin
        if (dbus_ack) begin
          state_d = StIdle;
`ifdef ACK_TIMEOUT_EN
        end else if (timeout) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      wreg_q   <= 1'b0;
      wd_q     <= 5'd0;
      ltype_q  <= 3'd0;
      lo_q     <= 2'd0;
      wb_we    <= 1'b0;
      wb_waddr <= 5'd0;
      wb_wdata <= 32'd0;
    end else begin
      state_q  <= state_d;
      wreg_q   <= wreg_d;
      wd_q     <= wd_d;
      ltype_q  <= ltype_d;
      lo_q     <= lo_d;
      wb_we    <= we_d;
      wb_waddr <= waddr_d;
      wb_wdata <= wdata_d;
    end
  end

`ifdef ACK_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      bus_err <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bus_err <= err_d;
    end
  end
`else
  assign bus_err = 1'b0;
`endif

  // Stall is held low throughout reset even if a load is presented.
  assign stallreq = rst && ((state_q != StIdle) || (mem_valid && mem_is_load && !flush));

endmodule
